conv_input: RTL and testbench

- AXI-Stream-style ingress stage of the conv accelerator, at the opposite end of the pipeline from the output stage.
- Accepts a row-major CONV_SIZE x CONV_SIZE image stream from the DMA side and buffers it in a 2-entry FIFO.
- Tags each pixel with its row/col position and a window-complete flag, then feeds the line-buffer/multiplier side.
- Checks upstream framing (last) against the expected image size.

---
 rtl/conv_input.sv | 124 ++++++++++++
 tb/tb_conv_input.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_input.sv
// Ingress stage for the conv pipeline: 2-entry FIFO tagging each pixel with row/col/window/last.
// Define CONV_INPUT_LAST_CHECK_EN to check upstream s_last framing (err_last, counter resync).
module conv_input #(
  parameter int WIDTH       = 32,
  parameter int CONV_SIZE   = 28,
  parameter int KERNEL_SIZE = 5,
  localparam int PW = ($clog2(CONV_SIZE) > 1) ? $clog2(CONV_SIZE) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             conv_valid,
  input  logic             conv_ready,
  output logic [WIDTH-1:0] conv_data,
  output logic [PW-1:0]    conv_row,
  output logic [PW-1:0]    conv_col,
  output logic             conv_win,
  output logic             conv_last,
  output logic             err_last
);

  // state  | meaning
  // IDLE   | at (0,0), nothing accepted yet for this image
  // STREAM | image in progress
  typedef enum logic {IDLE, STREAM} state_t;

  localparam int EW = WIDTH + 2*PW + 2;
  localparam logic [PW-1:0] LAST_IDX = PW'(CONV_SIZE - 1);
  localparam logic [PW-1:0] WIN_IDX  = PW'(KERNEL_SIZE - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] row_q, col_q, row_d, col_d;
  logic [EW-1:0] mem_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q;
  logic          en_q, err_q;
  logic          accept, xfer, pos_last, tag_last, resync, err_set, win;
  logic [EW-1:0] wr_entry, head;

  // en_q keeps s_ready low while reset is held, without any path from conv_ready.
  assign s_ready    = en_q & (count_q != 2'd2);
  assign conv_valid = (count_q != 2'd0);
  assign accept     = s_valid & s_ready;
  assign xfer       = conv_valid & conv_ready;
  assign pos_last   = (row_q == LAST_IDX) && (col_q == LAST_IDX);
  assign win        = (row_q >= WIN_IDX) && (col_q >= WIN_IDX);

`ifdef CONV_INPUT_LAST_CHECK_EN
  assign tag_last = pos_last | s_last;
  assign resync   = s_last;
  assign err_set  = accept & (s_last ^ pos_last);
`else
  logic last_unused;
  assign last_unused = s_last;
  assign tag_last    = pos_last;
  assign resync      = 1'b0;
  assign err_set     = 1'b0;
`endif

  assign wr_entry = {s_data, row_q, col_q, win, tag_last};
  assign head     = mem_q[rd_ptr_q];
  assign {conv_data, conv_row, conv_col, conv_win, conv_last} = conv_valid ? head : '0;
  assign err_last = err_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (accept) begin
      if (pos_last || resync) begin
        row_d = '0;
        col_d = '0;
      end else if (col_q == LAST_IDX) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !(pos_last || resync)) state_d = STREAM;
      STREAM:  if (accept && (pos_last || resync))  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      en_q     <= 1'b0;
      err_q    <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      en_q    <= 1'b1;
      err_q   <= err_q | err_set;
      if (accept) begin
        mem_q[wr_ptr_q] <= wr_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (xfer) rd_ptr_q <= ~rd_ptr_q;
      case ({accept, xfer})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_input.sv
// Directed bench for conv_input at CONV_SIZE=4, KERNEL_SIZE=3, WIDTH=8.
module tb_conv_input;
  localparam int W  = 8;
  localparam int CS = 4;
  localparam int KS = 3;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, s_last;
  logic [W-1:0]  s_data;
  logic          conv_valid, conv_ready, conv_win, conv_last, err_last;
  logic [W-1:0]  conv_data;
  logic [PW-1:0] conv_row, conv_col;

  int n_pass  = 0;
  int n_total = 0;

  conv_input #(.WIDTH(W), .CONV_SIZE(CS), .KERNEL_SIZE(KS)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .conv_valid(conv_valid), .conv_ready(conv_ready), .conv_data(conv_data),
    .conv_row(conv_row), .conv_col(conv_col), .conv_win(conv_win),
    .conv_last(conv_last), .err_last(err_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Streams n pixels (data = index) with conv_ready high; images of 16 pixels, s_last on 15.
  task automatic stream_img(input int n);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        int p, q;
        p = i - 1;
        q = p % 16;
        check("st_valid", 32'(conv_valid), 32'd1);
        check("st_data",  32'(conv_data),  32'(p % 256));
        check("st_row",   32'(conv_row),   32'(q / 4));
        check("st_col",   32'(conv_col),   32'(q % 4));
        check("st_win",   32'(conv_win),   32'(q == 10 || q == 11 || q == 14 || q == 15));
        check("st_last",  32'(conv_last),  32'(q == 15));
        check("st_err",   32'(err_last),   32'd0);
      end
      if (i < n) begin
        check("st_ready", 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        s_data  = 8'(i);
        s_last  = (i % 16 == 15);
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, rcv;
    logic stall_prev;
    logic [W+2*PW-1:0] held;

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; conv_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(s_ready),    32'd0);
    check("rst_valid", 32'(conv_valid), 32'd0);
    check("rst_data",  32'(conv_data),  32'd0);
    check("rst_pos",   32'({conv_row, conv_col, conv_win, conv_last}), 32'd0);
    check("rst_err",   32'(err_last),   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel_ready", 32'(s_ready), 32'd1);

    // single image at full rate
    conv_ready = 1'b1;
    stream_img(16);
    @(negedge clk);
    check("drain_valid", 32'(conv_valid), 32'd0);

    // backpressure: fill the FIFO, then release
    conv_ready = 1'b0; s_valid = 1'b1; s_data = 8'd0;
    @(negedge clk);
    check("bp_ready1", 32'(s_ready),   32'd1);
    check("bp_data0",  32'(conv_data), 32'd0);
    s_data = 8'd1;
    @(negedge clk);
    check("bp_full",   32'(s_ready),    32'd0);
    check("bp_valid",  32'(conv_valid), 32'd1);
    check("bp_hold0",  32'(conv_data),  32'd0);
    s_data = 8'd2;
    @(negedge clk);
    check("bp_full2",  32'(s_ready),   32'd0);
    check("bp_hold0b", 32'(conv_data), 32'd0);
    conv_ready = 1'b1;
    @(negedge clk);
    check("bp_data1",  32'(conv_data), 32'd1);
    check("bp_col1",   32'(conv_col),  32'd1);
    check("bp_ready2", 32'(s_ready),   32'd1);
    @(negedge clk);
    check("bp_data2",  32'(conv_data), 32'd2);
    check("bp_col2",   32'(conv_col),  32'd2);
    s_valid = 1'b0;
    @(negedge clk);
    check("bp_empty",  32'(conv_valid), 32'd0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // toggling conv_ready with s_valid held high
    sent = 0; rcv = 0; stall_prev = 1'b0; held = '0; conv_ready = 1'b0;
    for (int cyc = 0; cyc < 100 && rcv < 16; cyc++) begin
      @(negedge clk);
      if (stall_prev) check("tog_stable", 32'({conv_data, conv_row, conv_col}), 32'(held));
      conv_ready = ~conv_ready;
      if (conv_valid && conv_ready) begin
        check("tog_data", 32'(conv_data), 32'(rcv));
        check("tog_row",  32'(conv_row),  32'(rcv / 4));
        check("tog_col",  32'(conv_col),  32'(rcv % 4));
        check("tog_last", 32'(conv_last), 32'(rcv == 15));
        rcv++;
      end
      stall_prev = conv_valid && !conv_ready;
      held = {conv_data, conv_row, conv_col};
      if (sent < 16) begin
        s_valid = 1'b1;
        s_data  = 8'(sent);
        s_last  = (sent == 15);
        if (s_ready) sent++;
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
    end
    check("tog_count", 32'(rcv), 32'd16);
    s_valid = 1'b0; s_last = 1'b0;

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // s_last on pixel 5 (early last)
    conv_ready = 1'b1;
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      if (i > 0) begin
        int p;
        p = i - 1;
        check("el_data", 32'(conv_data), 32'(p));
`ifdef CONV_INPUT_LAST_CHECK_EN
        check("el_row",  32'(conv_row),  32'((p == 6) ? 0 : p / 4));
        check("el_col",  32'(conv_col),  32'((p == 6) ? 0 : p % 4));
        check("el_last", 32'(conv_last), 32'(p == 5));
        check("el_err",  32'(err_last),  32'(p >= 5));
`else
        check("el_row",  32'(conv_row),  32'(p / 4));
        check("el_col",  32'(conv_col),  32'(p % 4));
        check("el_last", 32'(conv_last), 32'd0);
        check("el_err",  32'(err_last),  32'd0);
`endif
      end
      if (i < 7) begin
        s_valid = 1'b1;
        s_data  = 8'(i);
        s_last  = (i == 5);
      end else begin
        conv_ready = 1'b0;
        s_valid    = 1'b1;
        s_data     = 8'd7;
        s_last     = 1'b0;
      end
    end
    @(negedge clk);
    check("mr_full", 32'(s_ready), 32'd0);
    s_valid = 1'b0;

    // reset with buffered pixels
    rst = 1'b1;
    #1;
    check("mr_valid", 32'(conv_valid), 32'd0);
    check("mr_ready", 32'(s_ready),    32'd0);
    check("mr_err",   32'(err_last),   32'd0);
    check("mr_data",  32'(conv_data),  32'd0);
    @(negedge clk);
    check("mr_valid2", 32'(conv_valid), 32'd0);
    check("mr_ready2", 32'(s_ready),    32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mr_rel", 32'(s_ready), 32'd1);

    // two back-to-back images
    conv_ready = 1'b1;
    stream_img(32);
    @(negedge clk);
    check("b2b_drain", 32'(conv_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
